// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART with TX/RX FIFOs, programmable baud divisor, optional parity
// and maskable level interrupt, on a 16-bit zero-wait-state peripheral bus.
module uart_fifo_ctrl #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DEFAULT_DIVISOR = 434,
  parameter int unsigned PARITY          = 0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [2:0]  wire_address,
  input  logic        wire_chipselect,
  input  logic        wire_read_n,
  input  logic        wire_write_n,
  input  logic [15:0] wire_writedata,
  output logic [15:0] wire_readdata,
  output logic        int_irq
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  LastBit   = 4'(DATA_BITS - 1);
  localparam bit          HasParity = (PARITY != 0);
  localparam logic [15:0] DefDiv    = 16'(DEFAULT_DIVISOR);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : ^d;
  endfunction

  logic bus_rd, bus_wr;
  assign bus_rd = wire_chipselect & ~wire_read_n;
  assign bus_wr = wire_chipselect & ~wire_write_n;

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wptr_q, tx_rptr_q;
  logic                 tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty   = (tx_wptr_q == tx_rptr_q);
  assign tx_full    = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_push    = bus_wr && (wire_address == 3'd1) && !tx_full;
  assign tx_ovf_set = bus_wr && (wire_address == 3'd1) && tx_full;
  assign tx_head    = tx_mem[tx_rptr_q[AW-1:0]];

  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= wire_writedata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wptr_q, rx_rptr_q;
  logic                 rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_BITS-1:0] rx_head, rx_shift_q;
  logic [7:0]           rx_count;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_pop   = bus_rd && (wire_address == 3'd0) && !rx_empty;
  assign rx_head  = rx_mem[rx_rptr_q[AW-1:0]];
  assign rx_count = 8'(rx_wptr_q - rx_rptr_q);

  always_ff @(posedge clk_clk) begin
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  // TX shifter
  state_e               tx_state_q;
  logic [15:0]          tx_cnt_q, tx_div_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic [3:0]           tx_bit_q;
  logic                 tx_par_q, txd_q, tx_bit_end, tx_idle;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
  assign tx_idle    = tx_empty && (tx_state_q == StIdle);
  // Popping at the end of STOP chains frames with no idle bit in between.
  assign tx_pop     = !tx_empty && ((tx_state_q == StIdle) ||
                                    ((tx_state_q == StStop) && tx_bit_end));

  logic [15:0] div_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= DefDiv;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= StStart;
      tx_cnt_q   <= '0;
      tx_div_q   <= div_q;
      tx_shift_q <= tx_head;
      tx_par_q   <= par_bit(tx_head);
      tx_bit_q   <= '0;
      txd_q      <= 1'b0;
    end else if (tx_state_q != StIdle) begin
      if (!tx_bit_end) begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          StStart: begin
            tx_state_q <= StData;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
          StData: begin
            if (tx_bit_q == LastBit) begin
              tx_state_q <= HasParity ? StParity : StStop;
              txd_q      <= HasParity ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          StParity: begin
            tx_state_q <= StStop;
            txd_q      <= 1'b1;
          end
          default: begin
            tx_state_q <= StIdle;
            txd_q      <= 1'b1;
          end
        endcase
      end
    end
  end

  // RX receiver
  state_e      rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [3:0]  rx_bit_q;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_par_q;
  logic        rx_bit_end, rx_half_end, rx_stop_done;
  logic        rx_ferr_set, rx_ovr_set, rx_perr_set;

  assign rx_bit_end   = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half_end  = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
  assign rx_stop_done = (rx_state_q == StStop) && rx_bit_end;
  assign rx_push      = rx_stop_done && rx_sync_q && !rx_full;
  assign rx_ferr_set  = rx_stop_done && !rx_sync_q;
  assign rx_ovr_set   = rx_stop_done && rx_sync_q && rx_full;
  assign rx_perr_set  = HasParity && rx_stop_done && rx_sync_q &&
                        (rx_par_q != par_bit(rx_shift_q));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= DefDiv;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_meta_q <= uart_rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      case (rx_state_q)
        StIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= StStart;
            rx_cnt_q   <= '0;
            rx_div_q   <= div_q;
          end
        end
        StStart: begin
          if (!rx_half_end) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end else begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? StIdle : StData;
          end
        end
        default: begin
          if (!rx_bit_end) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end else begin
            rx_cnt_q <= '0;
            case (rx_state_q)
              StData: begin
                rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == LastBit) rx_state_q <= HasParity ? StParity : StStop;
                else                     rx_bit_q   <= rx_bit_q + 4'd1;
              end
              StParity: begin
                rx_par_q   <= rx_sync_q;
                rx_state_q <= StStop;
              end
              default: rx_state_q <= StIdle;
            endcase
          end
        end
      endcase
    end
  end

  // Control/status registers and interrupt
  logic [2:0] ctrl_q;
  logic       ovr_q, ferr_q, perr_q, txovf_q, irq_q, w1c;

  assign w1c = bus_wr && (wire_address == 3'd2);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_q  <= '0;
      div_q   <= DefDiv;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      txovf_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (bus_wr && (wire_address == 3'd3)) ctrl_q <= wire_writedata[2:0];
      if (bus_wr && (wire_address == 3'd4)) begin
        div_q <= (wire_writedata < 16'd4) ? 16'd4 : wire_writedata;
      end
      // A new event in the same cycle as its clear wins.
      ovr_q   <= rx_ovr_set  | (ovr_q   & ~(w1c & wire_writedata[3]));
      ferr_q  <= rx_ferr_set | (ferr_q  & ~(w1c & wire_writedata[4]));
      perr_q  <= rx_perr_set | (perr_q  & ~(w1c & wire_writedata[5]));
      txovf_q <= tx_ovf_set  | (txovf_q & ~(w1c & wire_writedata[6]));
      irq_q   <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle) |
                 (ctrl_q[2] & (ovr_q | ferr_q | perr_q | txovf_q));
    end
  end

  always_comb begin
    wire_readdata = '0;
    case (wire_address)
      3'd0:    if (!rx_empty) wire_readdata = 16'(rx_head);
      3'd2:    wire_readdata = {rx_count, 1'b0, txovf_q, perr_q, ferr_q, ovr_q,
                                tx_full, tx_idle, !rx_empty};
      3'd3:    wire_readdata = {13'd0, ctrl_q};
      3'd4:    wire_readdata = div_q;
      default: wire_readdata = '0;
    endcase
  end

  assign uart_txd = txd_q;
  assign int_irq  = irq_q;

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Parametrised memory-mapped UART controller with independent TX and RX FIFOs, a runtime-programmable baud divisor, configurable data width and parity, and maskable interrupts. It sits on the processor's 16-bit peripheral bus as a zero-wait-state slave and drives the board serial pins. It replaces the fixed-configuration UART with one that software can tune and that buffers whole bursts of traffic.

Parameters:
DATA_BITS, 8, frame data width; legal range 5-9.
FIFO_DEPTH, 16, entries per TX/RX FIFO; power of two, range 2-128.
DEFAULT_DIVISOR, 434, clocks per bit after reset (50 MHz / 115200).
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
clk_clk  in  1  system clock; all logic on its rising edge
reset_reset_n  in  1  asynchronous active-low reset
uart_rxd  in  1  serial input, asynchronous to clk_clk
uart_txd  out  1  serial output
wire_address  in  3  register select
wire_chipselect  in  1  slave select
wire_read_n  in  1  active-low read strobe
wire_write_n  in  1  active-low write strobe
wire_writedata  in  16  write data
wire_readdata  out  16  read data
int_irq  out  1  level interrupt, active high

Behaviour:
- Reset, asynchronous: uart_txd=1; int_irq=0; both FIFOs empty; CTRL=0; DIV=DEFAULT_DIVISOR; sticky flags=0; TX and RX FSMs in IDLE.
- Bus access: a read occurs when wire_chipselect=1 and wire_read_n=0; a write occurs when wire_chipselect=1 and wire_write_n=0.
- wire_readdata is combinational from wire_address in the same cycle. Side effects (FIFO pop, flag clear) take place at the clock edge ending the access.
- Register map:
  - 0 RXDATA (R): [DATA_BITS-1:0] = RX FIFO head, upper bits 0. A read pops one entry. Reading an empty FIFO returns 0 and does not pop.
  - 1 TXDATA (W): pushes [DATA_BITS-1:0]. A write while the FIFO is full is dropped and sets TXOVF.
  - 2 STATUS (R / W1C): bit0 RX non-empty; bit1 TX idle (FIFO empty and shifter idle); bit2 TX full; bit3 RX overrun; bit4 framing error; bit5 parity error; bit6 TXOVF; [15:8] RX FIFO count. Writing 1 to any of bits 3-6 clears that bit.
  - 3 CTRL (R/W): bit0 RX-data irq enable; bit1 TX-idle irq enable; bit2 error irq enable; other bits read 0.
  - 4 DIV (R/W): 16-bit clocks per bit. A written value below 4 is stored as 4. A new value takes effect at the next frame start; a frame in progress keeps its old value.
  - 5-7: read 0; writes ignored.
- int_irq is registered, one cycle after its cause:
  - (CTRL0 & RX non-empty) | (CTRL1 & TX idle) | (CTRL2 & any of bits 3-6).
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Leaves IDLE when the TX FIFO is non-empty; pops the FIFO on the IDLE->START transition.
  - Each state holds for DIV clocks. Data is sent LSB first. STOP is one bit, driven 1.
  - Back-to-back frames: no idle bit between them when the FIFO still holds data at the end of STOP.
- RX path:
  - uart_rxd passes through a 2-flop synchroniser.
  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP.
  - A falling edge in IDLE starts a count. The line is re-sampled at DIV/2 (integer division); if it is 1 there, this is a false start and the FSM returns to IDLE.
  - Later bits are sampled every DIV clocks from the mid-bit point.
  - STOP sample = 0: sets framing error and the byte is discarded.
  - Parity mismatch: sets parity error and the byte is still pushed.
  - RX FIFO full at STOP: byte discarded and overrun set.
  - An RX push and a bus pop in the same cycle are both honoured; the count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full and empty are decided by comparing the MSB and the remaining bits of the two pointers, so wrap-around needs no special case.
- Reset asserted mid-frame: uart_txd returns to 1 immediately and any partial RX frame is lost.

Test Plan:
- Reset with DEFAULT_DIVISOR -> uart_txd=1, STATUS=0x0002, DIV reads 434, int_irq=0.
- DIV=16; write TXDATA=0xA5 -> uart_txd low 16 clks, then bits 1,0,1,0,0,1,0,1 of 16 clks each, then stop high; STATUS bit1 returns to 1 after 160 clks.
- DIV=16, loopback uart_txd->uart_rxd; write 0x3C, 0x81 back-to-back -> no idle gap on the line; STATUS[15:8]=2; RXDATA reads return 0x3C then 0x81; count then reads 0.
- 16-deep RX FIFO; drive 17 frames without reading -> count=16, overrun bit3=1; write STATUS=0x0008 -> bit3=0.
- Frame with stop bit forced 0 -> bit4=1, count unchanged. Glitch on uart_rxd shorter than DIV/2 -> no frame received.
- CTRL=0x1; receive one byte -> int_irq=1 one cycle after the push; read RXDATA -> int_irq=0 on the next cycle.
